// File: rtl/booth_r4_seq_mult_pkg.sv
// Shared definitions for the radix-4 Booth sequential multiplier:
// FSM state encoding and the layout of the recoded digit.
package booth_r4_seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude of the selected multiple; sign carried separately in NEG_BIT.
    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_A    = 2'd1;
    localparam logic [1:0] SEL_2A   = 2'd2;

    localparam int NEG_BIT = 0;
    localparam int SEL_LSB = 1;

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth recoder: multiplier bit triple -> {sel[1:0], neg}.
module booth_r4_recode
    import booth_r4_seq_mult_pkg::*;
(
    input  logic [2:0] triple,
    output logic [2:0] code
);

    always_comb begin
        code = {SEL_ZERO, 1'b0};
        case (triple)
            3'b000, 3'b111: code = {SEL_ZERO, 1'b0};
            3'b001, 3'b010: code = {SEL_A,    1'b0};
            3'b011:         code = {SEL_2A,   1'b0};
            3'b100:         code = {SEL_2A,   1'b1};
            3'b101, 3'b110: code = {SEL_A,    1'b1};
            default:        code = {SEL_ZERO, 1'b0};
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier, one digit per clock, signed or unsigned,
// valid/ready handshake on operands and product.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | ITER digit cycles, then one cycle to register prod
// DONE  | out_valid high, prod held until out_ready
module booth_r4_seq_mult
    import booth_r4_seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod
);

    localparam int ITER = WIDTH / 2 + 1;
    localparam int CW   = $clog2(ITER + 1);
    localparam int HW   = WIDTH + 3;
    localparam int LW   = WIDTH + 2;
    localparam logic [CW-1:0] LAST = CW'(ITER);

    state_t            state;
    logic [WIDTH-1:0]  a_reg;
    logic              sgn_reg;
    logic [WIDTH+2:0]  mpr;
    logic [HW-1:0]     acc_hi;
    logic [LW-1:0]     acc_lo;
    logic [CW-1:0]     iter_cnt;

    logic [2:0]        rec;
    logic [1:0]        sel;
    logic              neg;
    logic [HW-1:0]     a_ext;
    logic [HW-1:0]     mult;
    logic [HW-1:0]     sum;

    booth_r4_recode u_recode (
        .triple (mpr[2:0]),
        .code   (rec)
    );

    assign sel   = rec[SEL_LSB +: 2];
    assign neg   = rec[NEG_BIT];
    assign a_ext = {{3{sgn_reg & a_reg[WIDTH-1]}}, a_reg};

    always_comb begin
        mult = '0;
        case (sel)
            SEL_A:   mult = a_ext;
            SEL_2A:  mult = a_ext << 1;
            default: mult = '0;
        endcase
    end

    // Subtraction as invert-plus-one so one adder covers both signs.
    assign sum = acc_hi + (neg ? ~mult : mult) + {{(HW-1){1'b0}}, neg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            prod      <= '0;
            a_reg     <= '0;
            sgn_reg   <= 1'b0;
            mpr       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            iter_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        sgn_reg  <= is_signed;
                        mpr      <= {{2{is_signed & b[WIDTH-1]}}, b, 1'b0};
                        acc_hi   <= '0;
                        acc_lo   <= '0;
                        iter_cnt <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (iter_cnt == LAST) begin
                        prod      <= {acc_hi[WIDTH-3:0], acc_lo};
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        acc_hi   <= {{2{sum[HW-1]}}, sum[HW-1:2]};
                        acc_lo   <= {sum[1:0], acc_lo[LW-1:2]};
                        mpr      <= mpr >> 2;
                        iter_cnt <= iter_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed and randomised checks of booth_r4_seq_mult at WIDTH=8 and WIDTH=16.
module tb_booth_r4_seq_mult;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid8 = 1'b0, in_ready8, is_signed8 = 1'b0;
    logic        out_valid8, out_ready8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] prod8;

    logic        in_valid16 = 1'b0, in_ready16, is_signed16 = 1'b0;
    logic        out_valid16, out_ready16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] prod16;

    int checks = 0;
    int errors = 0;

    booth_r4_seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .is_signed(is_signed8), .out_valid(out_valid8),
        .out_ready(out_ready8), .prod(prod8)
    );

    booth_r4_seq_mult #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .is_signed(is_signed16), .out_valid(out_valid16),
        .out_ready(out_ready16), .prod(prod16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive operands and return just after the accept edge.
    task automatic start8(input logic [7:0] aa, input logic [7:0] bb, input logic s);
        int n = 0;
        a8 = aa; b8 = bb; is_signed8 = s; in_valid8 = 1'b1;
        while (!in_ready8 && n < 50) begin tick(); n++; end
        tick();
        in_valid8 = 1'b0;
    endtask

    task automatic start16(input logic [15:0] aa, input logic [15:0] bb, input logic s);
        int n = 0;
        a16 = aa; b16 = bb; is_signed16 = s; in_valid16 = 1'b1;
        while (!in_ready16 && n < 50) begin tick(); n++; end
        tick();
        in_valid16 = 1'b0;
    endtask

    // Edges after the accept edge until out_valid; also whether in_ready stayed low.
    task automatic wait_done8(output int edges, output bit rdy_low);
        edges = 0; rdy_low = 1'b1;
        while (!out_valid8 && edges < 40) begin
            if (in_ready8) rdy_low = 1'b0;
            tick(); edges++;
        end
    endtask

    task automatic wait_done16(output int edges);
        edges = 0;
        while (!out_valid16 && edges < 60) begin tick(); edges++; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready8); end
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid8); end
        checks++; if (prod8 !== 16'h0000) begin errors++; $display("FAIL reset_prod got %h want 0000", prod8); end
        checks++; if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0 || prod16 !== 32'h0)
            begin errors++; $display("FAIL reset_w16 got rdy=%b vld=%b prod=%h want 1 0 0", in_ready16, out_valid16, prod16); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned_max();
        int e; bit rl;
        out_ready8 = 1'b1;
        start8(8'd255, 8'd230, 1'b0);
        wait_done8(e, rl);
        checks++; if (e != 6) begin errors++; $display("FAIL uns_latency got %0d want 6", e); end
        checks++; if (prod8 !== 16'hE51A) begin errors++; $display("FAIL uns_255x230 got %h want e51a", prod8); end
        checks++; if (!rl) begin errors++; $display("FAIL uns_in_ready_low got high want low"); end
        tick();
    endtask

    task automatic test_signed();
        int e; bit rl;
        start8(8'h80, 8'h80, 1'b1);
        wait_done8(e, rl);
        checks++; if (prod8 !== 16'h4000) begin errors++; $display("FAIL sgn_80x80 got %h want 4000", prod8); end
        tick();
        start8(8'hFF, 8'h7F, 1'b1);
        wait_done8(e, rl);
        checks++; if (prod8 !== 16'hFF81) begin errors++; $display("FAIL sgn_ffx7f got %h want ff81", prod8); end
        tick();
        start8(8'h80, 8'h80, 1'b0);
        wait_done8(e, rl);
        checks++; if (prod8 !== 16'h4000) begin errors++; $display("FAIL uns_80x80 got %h want 4000", prod8); end
        tick();
        start8(8'hFF, 8'h7F, 1'b0);
        wait_done8(e, rl);
        checks++; if (prod8 !== 16'h7E81) begin errors++; $display("FAIL uns_ffx7f got %h want 7e81", prod8); end
        tick();
    endtask

    task automatic test_backpressure();
        int e; bit rl;
        out_ready8 = 1'b0;
        start8(8'd200, 8'd250, 1'b0);
        wait_done8(e, rl);
        checks++; if (out_valid8 !== 1'b1 || prod8 !== 16'hC350)
            begin errors++; $display("FAIL bp_first got vld=%b prod=%h want 1 c350", out_valid8, prod8); end
        a8 = 8'd3; b8 = 8'd7; is_signed8 = 1'b0; in_valid8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid8 !== 1'b1 || prod8 !== 16'hC350 || in_ready8 !== 1'b0)
                begin errors++; $display("FAIL bp_hold%0d got vld=%b prod=%h rdy=%b want 1 c350 0", i, out_valid8, prod8, in_ready8); end
        end
        out_ready8 = 1'b1;
        tick();
        checks++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0)
            begin errors++; $display("FAIL bp_release got rdy=%b vld=%b want 1 0", in_ready8, out_valid8); end
        tick();
        checks++; if (in_ready8 !== 1'b0) begin errors++; $display("FAIL bp_accept_next got rdy=%b want 0", in_ready8); end
        in_valid8 = 1'b0;
        wait_done8(e, rl);
        checks++; if (prod8 !== 16'd21) begin errors++; $display("FAIL bp_second got %h want 0015", prod8); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int e; bit rl;
        out_ready8 = 1'b1;
        start8(8'd100, 8'd100, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || prod8 !== 16'h0)
            begin errors++; $display("FAIL rst_mid got vld=%b rdy=%b prod=%h want 0 1 0000", out_valid8, in_ready8, prod8); end
        start8(8'd5, 8'd9, 1'b0);
        wait_done8(e, rl);
        checks++; if (prod8 !== 16'h002D || e != 6)
            begin errors++; $display("FAIL rst_after got prod=%h edges=%0d want 002d 6", prod8, e); end
        tick();
    endtask

    task automatic test_width16();
        int e;
        out_ready16 = 1'b1;
        start16(16'hFFFF, 16'hFFFF, 1'b0);
        wait_done16(e);
        checks++; if (e != 10) begin errors++; $display("FAIL w16_latency got %0d want 10", e); end
        checks++; if (prod16 !== 32'hFFFE0001) begin errors++; $display("FAIL w16_uns got %h want fffe0001", prod16); end
        tick();
        start16(16'h8000, 16'h7FFF, 1'b1);
        wait_done16(e);
        checks++; if (prod16 !== 32'hC0008000) begin errors++; $display("FAIL w16_sgn got %h want c0008000", prod16); end
        tick();
    endtask

    task automatic test_random8();
        int e; bit rl;
        logic [7:0] aa, bb; logic s; logic [15:0] exp_p;
        for (int i = 0; i < 1500; i++) begin
            aa = 8'($urandom); bb = 8'($urandom); s = 1'($urandom);
            if (s) exp_p = 16'(int'($signed(aa)) * int'($signed(bb)));
            else   exp_p = 16'(int'(aa) * int'(bb));
            repeat ($urandom_range(0, 2)) tick();
            out_ready8 = 1'b0;
            start8(aa, bb, s);
            wait_done8(e, rl);
            repeat ($urandom_range(0, 2)) tick();
            checks++; if (out_valid8 !== 1'b1 || prod8 !== exp_p)
                begin errors++; $display("FAIL rnd8 %h*%h s=%b got vld=%b prod=%h want %h", aa, bb, s, out_valid8, prod8, exp_p); end
            out_ready8 = 1'b1;
            tick();
        end
    endtask

    task automatic test_random16();
        int e;
        logic [15:0] aa, bb; logic s; logic [31:0] exp_p;
        for (int i = 0; i < 300; i++) begin
            aa = 16'($urandom); bb = 16'($urandom); s = 1'($urandom);
            if (s) exp_p = 32'(longint'($signed(aa)) * longint'($signed(bb)));
            else   exp_p = 32'(longint'(aa) * longint'(bb));
            repeat ($urandom_range(0, 2)) tick();
            out_ready16 = 1'b0;
            start16(aa, bb, s);
            wait_done16(e);
            repeat ($urandom_range(0, 2)) tick();
            checks++; if (out_valid16 !== 1'b1 || prod16 !== exp_p)
                begin errors++; $display("FAIL rnd16 %h*%h s=%b got vld=%b prod=%h want %h", aa, bb, s, out_valid16, prod16, exp_p); end
            out_ready16 = 1'b1;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_backpressure();
        test_reset_mid_run();
        test_width16();
        test_random8();
        test_random16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
